multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: opcode  in  7  instruction[6:0] from the instruction register; valid from DECODE onward.
REQ-004 SHALL have ports: zero  in  1  ALU branch-compare result; valid in EXEC.
REQ-005 SHALL have ports: mem_ready  in  1  memory completes the current request this cycle.
REQ-006 SHALL have ports: mem_req  out  1  memory request (instruction or data).
REQ-007 SHALL have ports: mem_we  out  1  write strobe qualifying mem_req.
REQ-008 SHALL have ports: mem_sel  out  1  address source: 0 = PC, 1 = ALU result.
REQ-009 SHALL have ports: ir_write  out  1  load the instruction register.
REQ-010 SHALL have ports: pc_write  out  1  update the PC.
REQ-011 SHALL have ports: pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
REQ-012 SHALL have ports: alu_op  out  3  ALU operation class.
REQ-013 SHALL have ports: alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate.
REQ-014 SHALL have ports: reg_write  out  1  register-file write enable.
REQ-015 SHALL have ports: wb_sel  out  2  write-back source: 00 = ALU, 01 = memory, 10 = PC+4.
REQ-016 SHALL have ports: retire  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-017 SHALL have ports: illegal  out  1  one-cycle pulse for an unsupported opcode.
REQ-018 SHALL have ports: state  out  3  current state, for debug.

Function
REQ-019 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; codes 6-7 SHALL go to IDLE.
REQ-020 Outputs SHALL be combinational from state, op_q and mem_ready; every output not listed for a state SHALL be 0.
REQ-021 IDLE: all outputs 0; next state FETCH.
REQ-022 FETCH: mem_req=1, mem_sel=0; hold while mem_ready=0; when mem_ready=1, ir_write=1, pc_write=1, pc_src=00, and next state is DECODE.
REQ-023 DECODE: op_q latches opcode.
REQ-024 DECODE: a supported opcode (LUI 0110111, JAL 1101111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011) SHALL go to EXEC.
REQ-025 DECODE: any other opcode SHALL raise illegal=1 and retire=1, and next state is FETCH.
REQ-026 EXEC: alu_op = 000 for LUI/JAL, 001 for BRANCH, 010 for LOAD, 011 for STORE, 100 for OPIMM; alu_src=0 for BRANCH, 1 otherwise.
REQ-027 EXEC, BRANCH: pc_write=zero, pc_src=01, retire=1; next state FETCH.
REQ-028 EXEC, JAL: pc_write=1, pc_src=10; next state WB.
REQ-029 EXEC, LUI/OPIMM: next state WB.
REQ-030 EXEC, LOAD/STORE: next state MEM.
REQ-031 MEM: mem_req=1, mem_sel=1, mem_we=1 for STORE only; hold while mem_ready=0.
REQ-032 MEM, on mem_ready=1: LOAD goes to WB; STORE asserts retire=1 and goes to FETCH.
REQ-033 WB: reg_write=1, retire=1; wb_sel=01 for LOAD, 10 for JAL, 00 otherwise; next state FETCH.
REQ-034 Zero-wait latency, counted from FETCH entry to retire: BRANCH 3 cycles, STORE/LUI/OPIMM/JAL 4, LOAD 5, illegal 2; each mem_ready=0 cycle SHALL add 1.
REQ-035 mem_ready SHALL be ignored outside FETCH and MEM; opcode SHALL be ignored outside DECODE.

Reset
REQ-036 rst_n=0 SHALL immediately force state=IDLE and op_q=0, with all outputs 0, including in mid-operation or mid-wait states.
REQ-037 The first FETCH SHALL occur on the second rising edge after rst_n deasserts.

Structure
REQ-038 Shared package riscv_ctrl_pkg SHALL hold the opcode constants, the state encoding, the alu_op codes, the pc_src codes and the wb_sel codes.
REQ-039 A combinational sub-module ctrl_decode (op_q -> alu_op, alu_src, instruction class, illegal) SHALL be instantiated; the FSM SHALL be in the top module.

Verification
REQ-040 Reset, then opcode 0010011, mem_ready=1 throughout -> states 0,1,2,3,5,1; reg_write=1 and wb_sel=00 only in WB; retire on cycle 4.
REQ-041 LOAD 0000011 with mem_ready=0 for 2 MEM cycles -> mem_req=1, mem_sel=1, mem_we=0 for 3 cycles; then WB with wb_sel=01; retire after 7 cycles.
REQ-042 BRANCH 1100011 with zero=1 -> EXEC: pc_write=1, pc_src=01, alu_src=0, alu_op=001; with zero=0 -> pc_write=0; both return to FETCH.
REQ-043 JAL 1101111 -> EXEC: pc_src=10, pc_write=1; WB: wb_sel=10, reg_write=1.
REQ-044 Opcode 0110011 -> illegal=1 and retire=1 in DECODE for one cycle; next state FETCH.
REQ-045 rst_n pulled low during a STORE MEM wait -> mem_req and mem_we drop to 0 in the same cycle; state=0; FETCH follows on the second edge after release.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RISC-V control FSM
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_BRANCH = 3'b001;
  localparam logic [2:0] ALU_LOAD   = 3'b010;
  localparam logic [2:0] ALU_STORE  = 3'b011;
  localparam logic [2:0] ALU_OPIMM  = 3'b100;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Instruction classes produced by ctrl_decode.
  localparam logic [2:0] CLS_LUI     = 3'd0;
  localparam logic [2:0] CLS_JAL     = 3'd1;
  localparam logic [2:0] CLS_BRANCH  = 3'd2;
  localparam logic [2:0] CLS_LOAD    = 3'd3;
  localparam logic [2:0] CLS_STORE   = 3'd4;
  localparam logic [2:0] CLS_OPIMM   = 3'd5;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decoder: ALU controls, class, illegal flag
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic [2:0] cls,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    alu_src = 1'b1;
    cls     = CLS_ILLEGAL;
    illegal = 1'b0;
    case (op)
      OP_LUI:    cls = CLS_LUI;
      OP_JAL:    cls = CLS_JAL;
      OP_BRANCH: begin
        cls     = CLS_BRANCH;
        alu_op  = ALU_BRANCH;
        alu_src = 1'b0;
      end
      OP_LOAD: begin
        cls    = CLS_LOAD;
        alu_op = ALU_LOAD;
      end
      OP_STORE: begin
        cls    = CLS_STORE;
        alu_op = ALU_STORE;
      end
      OP_OPIMM: begin
        cls    = CLS_OPIMM;
        alu_op = ALU_OPIMM;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V subset control FSM (fetch/decode/exec/mem/wb)
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [6:0] op_q;
  logic       run_q;
  logic [6:0] dec_op;
  logic [2:0] dec_alu_op;
  logic       dec_alu_src;
  logic [2:0] dec_cls;
  logic       dec_illegal;

  // In DECODE the live opcode is judged so illegal can pulse that same cycle.
  assign dec_op = (state_q == S_DECODE) ? opcode : op_q;
  assign state  = state_q;

  ctrl_decode u_decode (
    .op      (dec_op),
    .alu_op  (dec_alu_op),
    .alu_src (dec_alu_src),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  // run_q holds IDLE for one extra edge so the first FETCH lands on the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run_q) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = dec_illegal ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (dec_cls == CLS_BRANCH || dec_cls == CLS_ILLEGAL) state_d = S_FETCH;
        else if (dec_cls == CLS_LOAD || dec_cls == CLS_STORE) state_d = S_MEM;
        else state_d = S_WB;
      end
      S_MEM: if (mem_ready) state_d = (dec_cls == CLS_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          illegal = 1'b1;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        if (dec_cls == CLS_BRANCH) begin
          pc_write = zero;
          pc_src   = PC_BRANCH;
          retire   = 1'b1;
        end else if (dec_cls == CLS_JAL) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (dec_cls == CLS_STORE);
        retire  = mem_ready && (dec_cls == CLS_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        if (dec_cls == CLS_LOAD) wb_sel = WB_MEM;
        else if (dec_cls == CLS_JAL) wb_sel = WB_PC4;
        else wb_sel = WB_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_sel, ir_write, pc_write;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       alu_src, reg_write;
  logic [1:0] wb_sel;
  logic       retire, illegal;
  logic [2:0] state;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [6:0] JUNK   = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;

  typedef struct packed {
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [18:0] out;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        cur;
  bit          have_exp = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_lat = 0;
  logic [18:0] dut_out;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  assign dut_out = {state, mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src,
                    alu_op, alu_src, reg_write, wb_sel, retire, illegal};

  function automatic logic [18:0] mk(input logic [2:0] st, input logic req, input logic we,
                                     input logic sel, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic [2:0] aop,
                                     input logic asrc, input logic rw, input logic [1:0] wbs,
                                     input logic ret, input logic ill);
    return {st, req, we, sel, irw, pcw, pcs, aop, asrc, rw, wbs, ret, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [6:0] op, input logic z, input logic mr, input logic [18:0] o);
    rec_t r;
    r = {op, z, mr, o};
    exp_q.push_back(r);
  endtask

  task automatic push_idle();
    push(JUNK, L, H, mk(3'd0, L, L, L, L, L, 2'b00, 3'd0, L, L, 2'b00, L, L));
  endtask

  // Expected per-cycle behaviour of one instruction from FETCH entry to retire.
  task automatic build(input logic [6:0] op, input logic z, input int fw, input int mw);
    logic ld, st, br, jl, lu, im, legal;
    logic [2:0] aop;
    logic [1:0] wbs;
    ld = (op == LOAD);  st = (op == STORE); br = (op == BRANCH);
    jl = (op == JAL);   lu = (op == LUI);   im = (op == OPIMM);
    legal = ld | st | br | jl | lu | im;
    aop = (lu | jl) ? 3'd0 : br ? 3'd1 : ld ? 3'd2 : st ? 3'd3 : 3'd4;
    wbs = ld ? 2'b01 : jl ? 2'b10 : 2'b00;
    for (int i = 0; i < fw; i++)
      push(JUNK, !z, L, mk(3'd1, H, L, L, L, L, 2'b00, 3'd0, L, L, 2'b00, L, L));
    push(JUNK, !z, H, mk(3'd1, H, L, L, H, H, 2'b00, 3'd0, L, L, 2'b00, L, L));
    if (!legal) begin
      push(op, !z, H, mk(3'd2, L, L, L, L, L, 2'b00, 3'd0, L, L, 2'b00, H, H));
      return;
    end
    push(op, !z, H, mk(3'd2, L, L, L, L, L, 2'b00, 3'd0, L, L, 2'b00, L, L));
    push(JUNK, z, H, mk(3'd3, L, L, L, L, br ? z : jl,
                        br ? 2'b01 : jl ? 2'b10 : 2'b00, aop, !br, L, 2'b00, br, L));
    if (br) return;
    if (ld | st) begin
      for (int i = 0; i < mw; i++)
        push(JUNK, !z, L, mk(3'd4, H, st, H, L, L, 2'b00, 3'd0, L, L, 2'b00, L, L));
      push(JUNK, !z, H, mk(3'd4, H, st, H, L, L, 2'b00, 3'd0, L, L, 2'b00, st, L));
      if (st) return;
    end
    push(JUNK, !z, H, mk(3'd5, L, L, L, L, L, 2'b00, 3'd0, L, H, wbs, H, L));
  endtask

  task automatic drive_one();
    rec_t r;
    r = exp_q.pop_front();
    @(posedge clk);
    #1;
    opcode = r.op;
    zero = r.z;
    mem_ready = r.mr;
    cur = r;
    have_exp = 1'b1;
    @(negedge clk);
    #1;
    have_exp = 1'b0;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) drive_one();
  endtask

  task automatic run_all();
    while (exp_q.size() > 0) drive_one();
  endtask

  task automatic instr(input string name, input logic [6:0] op, input logic z,
                       input int fw, input int mw, input int lat);
    last_lat = 0;
    build(op, z, fw, mw);
    run_all();
    check(name, 32'(last_lat), 32'(lat));
  endtask

  always @(negedge clk) begin
    if (have_exp) begin
      check("cycle outputs", 32'(dut_out), 32'(cur.out));
      if (state == 3'd0) cyc = 0;
      else cyc++;
      if (retire) begin
        last_lat = cyc;
        cyc = 0;
      end
    end
  end

  initial begin
    #23;
    check("reset outputs", 32'(dut_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle();
    instr("opimm latency", OPIMM, L, 0, 0, 4);
    instr("load wait2 latency", LOAD, L, 0, 2, 7);
    instr("store fetchwait latency", STORE, L, 1, 0, 5);
    instr("branch taken latency", BRANCH, H, 0, 0, 3);
    instr("branch not taken latency", BRANCH, L, 0, 0, 3);
    instr("jal latency", JAL, L, 0, 0, 4);
    instr("lui latency", LUI, L, 0, 0, 4);
    instr("illegal latency", JUNK, L, 0, 0, 2);
    instr("load latency", LOAD, L, 0, 0, 5);

    build(STORE, L, 0, 3);
    run_n(5);
    @(posedge clk);
    #1;
    opcode = JUNK;
    mem_ready = 1'b0;
    #1;
    check("store wait mem_req", 32'(mem_req), 32'd1);
    check("store wait mem_we", 32'(mem_we), 32'd1);
    check("store wait state", 32'(state), 32'd4);
    rst_n = 1'b0;
    #1;
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset state", 32'(state), 32'd0);
    check("reset all outputs", 32'(dut_out), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_idle();
    instr("post-reset opimm latency", OPIMM, L, 0, 0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
